// File: rtl/gen_fib_pkg.sv
// gen_fib shared types and default sizes.
// Imported by the Fibonacci generator and its adder.
package gen_fib_pkg;

  localparam int FIB_IW = 6;
  localparam int FIB_OW = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_CALC,
    S_DONE
  } state_e;

endpackage

// File: rtl/fib_sat_add.sv
// Term adder with carry-out for gen_fib.
// GEN_FIB_SAT_EN clamps the sum to all-ones on carry or sat_i.
module fib_sat_add
  import gen_fib_pkg::*;
#(
  parameter int OUTPUT_WIDTH = FIB_OW
) (
  input  logic [OUTPUT_WIDTH-1:0] a_i,
  input  logic [OUTPUT_WIDTH-1:0] b_i,
  input  logic                    sat_i,
  output logic [OUTPUT_WIDTH-1:0] sum_o,
  output logic                    carry_o
);

  logic [OUTPUT_WIDTH:0] raw;

  assign raw     = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o = raw[OUTPUT_WIDTH];

`ifdef GEN_FIB_SAT_EN
  // once a carry has been seen every later term is pinned at all-ones
  assign sum_o = (sat_i | raw[OUTPUT_WIDTH]) ? '1 : raw[OUTPUT_WIDTH-1:0];
`else
  logic unused_sat;
  assign unused_sat = sat_i;
  assign sum_o      = raw[OUTPUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/gen_fib.sv
// Iterative generalised Fibonacci term generator.
// Define GEN_FIB_SAT_EN to saturate terms after overflow.
module gen_fib
  import gen_fib_pkg::*;
#(
  parameter int INPUT_WIDTH  = FIB_IW,
  parameter int OUTPUT_WIDTH = FIB_OW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [INPUT_WIDTH-1:0]  n,
  input  logic [OUTPUT_WIDTH-1:0] seed0,
  input  logic [OUTPUT_WIDTH-1:0] seed1,
  output logic [OUTPUT_WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    done,
  output logic                    busy,
  output logic [INPUT_WIDTH:0]    i_r
);

  localparam logic [INPUT_WIDTH:0] ONE = 1;

  state_e                  state_q;
  logic [INPUT_WIDTH-1:0]  n_q;
  logic [OUTPUT_WIDTH-1:0] s0_q;
  logic [OUTPUT_WIDTH-1:0] s1_q;
  logic [OUTPUT_WIDTH-1:0] x_q;
  logic [OUTPUT_WIDTH-1:0] y_q;
  logic [INPUT_WIDTH:0]    i_q;
  logic [OUTPUT_WIDTH-1:0] result_q;
  logic                    ovf_q;
  logic                    done_q;

  logic [OUTPUT_WIDTH-1:0] y_d;
  logic                    carry;
  logic                    ovf_d;
  logic                    last_d;
  logic [OUTPUT_WIDTH-1:0] result_d;

  fib_sat_add #(
    .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) u_add (
    .a_i    (x_q),
    .b_i    (y_q),
    .sat_i  (ovf_q),
    .sum_o  (y_d),
    .carry_o(carry)
  );

  // i_q is one bit wider than n so this compare never wraps
  always_comb begin
    ovf_d    = ovf_q | carry;
    last_d   = (i_q >= {1'b0, n_q});
    result_d = (n_q == '0) ? x_q : y_q;
  end

  // run control: latch, seed, iterate, then hold the answer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      s0_q     <= '0;
      s1_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (go) begin
            n_q     <= n;
            s0_q    <= seed0;
            s1_q    <= seed1;
            done_q  <= 1'b0;
            state_q <= S_INIT;
          end
        end
        S_INIT: begin
          x_q     <= s0_q;
          y_q     <= s1_q;
          i_q     <= ONE;
          ovf_q   <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_CALC;
        end
        S_CALC: begin
          if (!last_d) begin
            x_q   <= y_q;
            y_q   <= y_d;
            i_q   <= i_q + ONE;
            ovf_q <= ovf_d;
          end else if (!go) begin
            result_q <= result_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q == S_INIT) || (state_q == S_CALC);
  assign result   = result_q;
  assign overflow = ovf_q;
  assign done     = done_q;
  assign i_r      = i_q;

endmodule

// File: tb/tb_gen_fib.sv
// Scoreboard bench for gen_fib: model-predicted runs,
// monitor checks each done rise for value, flag and latency.
module tb_gen_fib;

  localparam int IW = 6;
  localparam int W  = 32;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          go    = 1'b0;
  logic [IW-1:0] n     = '0;
  logic [W-1:0]  seed0 = '0;
  logic [W-1:0]  seed1 = '0;
  logic [W-1:0]  result;
  logic          overflow;
  logic          done;
  logic          busy;
  logic [IW:0]   i_r;

  always #5 clk = ~clk;

  gen_fib #(
    .INPUT_WIDTH (IW),
    .OUTPUT_WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .n       (n),
    .seed0   (seed0),
    .seed1   (seed1),
    .result  (result),
    .overflow(overflow),
    .done    (done),
    .busy    (busy),
    .i_r     (i_r)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           edge_n;
    int           ir;
  } exp_t;

  exp_t         exp_q[$];
  int           cyc = 0;
  int           n_pass = 0;
  int           n_tot = 0;
  logic         done_prev = 1'b0;
  logic [W-1:0] last_res = '0;
  logic         last_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exv);
    n_tot++;
    if (act === exv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exv);
  endtask

  // term n of the sequence, wrapping mod 2^W, flag on any carry
  function automatic void model(input int nn, input logic [W-1:0] s0,
                                input logic [W-1:0] s1,
                                output logic [W-1:0] r, output logic o);
    longint unsigned a, b, t, lim;
    lim = 64'd1 << W;
    a = 64'(s0);
    b = 64'(s1);
    o = 1'b0;
    for (int k = 2; k <= nn; k++) begin
      t = a + b;
      if (t >= lim) begin
        o = 1'b1;
        t = t - lim;
      end
`ifdef GEN_FIB_SAT_EN
      if (o) t = lim - 1;
`endif
      a = b;
      b = t;
    end
    r = (nn == 0) ? a[W-1:0] : b[W-1:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_done: got done=1 at edge %0d required none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'(result), 64'(e.res));
          chk("overflow", 64'(overflow), 64'(e.ovf));
          chk("done_edge", 64'(cyc), 64'(e.edge_n));
          chk("busy_at_done", 64'(busy), 64'(1'b0));
          chk("i_r_at_done", 64'(i_r), 64'(e.ir));
          last_res = e.res;
          last_ovf = e.ovf;
        end
      end else if (done && done_prev) begin
        chk("hold_result", 64'(result), 64'(last_res));
        chk("hold_ovf", 64'(overflow), 64'(last_ovf));
      end
    end
    done_prev <= done;
  end

  task automatic wait_empty();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      n     = IW'($urandom);
      seed0 = $urandom;
      seed1 = $urandom;
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tot++;
      $display("FAIL timeout: got no done after %0d cycles required done", k);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input int nn, input logic [W-1:0] s0,
                     input logic [W-1:0] s1, input int hold);
    exp_t         e;
    logic [W-1:0] r;
    logic         o;
    logic         was_done;
    int           lat;
    was_done = done;
    model(nn, s0, s1, r, o);
    lat = ((nn == 0) ? 1 : nn) + 1;
    e.res    = r;
    e.ovf    = o;
    e.ir     = (nn == 0) ? 1 : nn;
    e.edge_n = cyc + 1 + ((lat > hold) ? lat : hold);
    n     = IW'(nn);
    seed0 = s0;
    seed1 = s1;
    go    = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    if (was_done) begin
      chk("restart_done_clr", 64'(done), 64'(1'b0));
      chk("restart_hold_res", 64'(result), 64'(last_res));
    end
    for (int k = 1; k < hold; k++) @(negedge clk);
    go = 1'b0;
    wait_empty();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ir", 64'(i_r), 64'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));

    run(10, 0, 1, 1);
    run(5, 2, 1, 1);
    run(0, 7, $urandom, 1);
    run(47, 0, 1, 1);
    run(48, 0, 1, 1);
    run(3, 0, 1, 20);

    n     = 6'd30;
    seed0 = 0;
    seed1 = 1;
    go    = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_mid_run", 64'(busy), 64'(1'b1));
    #2 rst = 1'b0;
    #1;
    chk("arst_result", 64'(result), 64'(0));
    chk("arst_ovf", 64'(overflow), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_ir", 64'(i_r), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_done", 64'(done), 64'(0));

    run(4, 0, 1, 1);
    run(63, 0, 1, 1);
    run(1, $urandom, $urandom, 1);

    repeat (25) begin
      run(int'($urandom_range(0, 63)), $urandom, $urandom,
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/gen_fib.md
GEN_FIB -- requirements
Module: gen_fib

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 6: width of the term index n.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 32: width of the seeds and the result.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port go, input, 1 bit: start request, level-sampled.
REQ-006 SHALL have port n, input, INPUT_WIDTH bits: index of the requested term.
REQ-007 SHALL have port seed0, input, OUTPUT_WIDTH bits: term 0.
REQ-008 SHALL have port seed1, input, OUTPUT_WIDTH bits: term 1.
REQ-009 SHALL have port result, output, OUTPUT_WIDTH bits: term n.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set when any addition in the run carried out.
REQ-011 SHALL have port done, output, 1 bit: the run is complete and the outputs are valid.
REQ-012 SHALL have port busy, output, 1 bit: high in INIT and CALC.
REQ-013 SHALL have port i_r, output, INPUT_WIDTH+1 bits: current iteration index.

Function
REQ-014 SHALL implement FSM states IDLE, INIT, CALC and DONE.
REQ-015 SHALL, with go=1 sampled in IDLE or DONE, latch n, seed0 and seed1 and move to INIT.
REQ-016 SHALL ignore go while busy; the latched inputs SHALL NOT change during a run.
REQ-017 SHALL, in INIT: set x=seed0, y=seed1, i_r=1, overflow=0 and done=0, then move to CALC.
REQ-018 SHALL, in CALC with i_r<n: set x<=y and y<=x+y, increment i_r, and OR the adder carry-out into overflow.
REQ-019 SHALL, in CALC with i_r>=n and go=0: set result to x if n=0 else y, set done=1, and move to DONE.
REQ-020 SHALL, in CALC with i_r>=n and go=1: hold all state in CALC until go=0, so that done never rises in the cycle after a go=1 sample.
REQ-021 SHALL assert done max(n,1)+1 rising edges after the edge that samples go, when go is low.
REQ-022 SHALL hold done, result and overflow stable in DONE while go=0.
REQ-023 SHALL clear done on the edge after go=1 is sampled in DONE, since the FSM enters INIT.
REQ-024 SHALL, without saturation, produce arithmetic modulo 2^OUTPUT_WIDTH.
REQ-025 SHALL accept the boundary n=2^INPUT_WIDTH-1; i_r is one bit wider than n so its compare cannot wrap.

Reset
REQ-026 SHALL, on rst=0 at any time including mid-run, immediately force: state IDLE, result=0, overflow=0, done=0, busy=0, i_r=0, x=0, y=0.
REQ-027 SHALL, after rst is released, require a fresh go to start a run.

Configuration
REQ-028 SHALL, with macro GEN_FIB_SAT_EN defined, saturate y and every later term to all-ones once overflow is set, so that result reads 2^OUTPUT_WIDTH-1.
REQ-029 SHALL, without GEN_FIB_SAT_EN, wrap results while overflow still flags the carry.
REQ-030 SHALL have identical latency and the same overflow behaviour in both configurations.

Structure
REQ-031 SHALL place in package gen_fib_pkg:
- the state enum;
- the default INPUT_WIDTH and OUTPUT_WIDTH constants.
REQ-032 SHALL contain one sub-module, fib_sat_add: parametrised OUTPUT_WIDTH adder with carry-out; saturation logic is gated by GEN_FIB_SAT_EN.

Verification
REQ-033 SHALL cover: seeds 0/1, n=10, go pulsed 1 cycle -> result=55, overflow=0, done at edge 11, busy low once done.
REQ-034 SHALL cover: seeds 2/1 (Lucas), n=5 -> result=11; then n=0 with seed0=7 -> result=7, done at edge 2.
REQ-035 SHALL cover: seeds 0/1, n=47 -> result=2971215073, overflow=0; n=48 -> overflow=1 and result=512559680, or 0xFFFFFFFF with GEN_FIB_SAT_EN.
REQ-036 SHALL cover: go held high for 20 cycles with n=3 -> done stays 0 until the cycle after go falls; then result=2.
REQ-037 SHALL cover: rst=0 asserted in CALC with n=30 -> all outputs 0 immediately; new go with n=4 -> result=3.
REQ-038 SHALL cover: go=1 in DONE with new inputs -> done=0 next edge; the previous result is held until the new result loads.
